fetch_seq: RTL

Instruction fetch sequencer that feeds the decode unit of the breadboard CPU. It owns the program counter and fetches the 16-bit instruction word from instruction memory over a req/ack handshake. When the opcode demands it, it also fetches the following extension word. It then presents both to decode with a one-cycle `ins_en` pulse and waits for the execute stage to report completion and any PC redirect (`set_pc` / `add_pc` / `inc_pc`) before fetching the next instruction. The CPU is strictly non-pipelined: one instruction is in flight at a time.

---
 rtl/fetch_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_seq
//  Description : Instruction fetch sequencer for the breadboard CPU. Owns the
//                program counter, reads the instruction word (and an optional
//                extension word) from instruction memory over a req/ack
//                handshake, issues both to decode with a one-cycle ins_en
//                pulse, then waits for execute to finish and redirect the PC.
//                Strictly non-pipelined: one instruction in flight at a time.
//  Ports       :
//    cpu_clk, cpu_rst        clock / synchronous active-high reset
//    run                     fetch enable (sampled in IDLE and end of EXEC)
//    mem_req/mem_addr        instruction memory read request and word address
//    mem_ack/mem_rdata       read complete strobe and read data
//    ins/ext/ins_en          instruction, extension word, issue pulse
//    exec_done               execute stage finished current instruction
//    set_pc/add_pc/inc_pc    PC update selects, qualified by exec_done
//    pc_target               absolute target or two's-complement offset
//    cur_pc                  address of the instruction held in ins
//    idle                    high while the sequencer sits in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] EXT_MASK  = 16'h8000,
    parameter logic [15:0] EXT_MATCH = 16'h8000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        run,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ins,
    output logic [15:0] ext,
    output logic        ins_en,
    input  logic        exec_done,
    input  logic        set_pc,
    input  logic        add_pc,
    input  logic        inc_pc,
    input  logic [15:0] pc_target,
    output logic [15:0] cur_pc,
    output logic        idle
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_I = 3'd1;
    localparam logic [2:0] S_FETCH_E = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_cur_pc;
    logic [15:0] r_ins;
    logic [15:0] r_ext;
    logic        r_has_ext;     // current instruction carried an extension word
    logic        w_need_ext;
    logic [15:0] w_seq_pc;
    logic [15:0] w_pc_nxt;

    // Extension decision is made on the raw read data so the FETCH_E decision
    // is taken in the same cycle as the instruction ack.
    assign w_need_ext = ((mem_rdata & EXT_MASK) == EXT_MATCH);

    // Sequential advance skips over the extension word when one was fetched.
    assign w_seq_pc = r_cur_pc + (r_has_ext ? 16'd2 : 16'd1);

    always_comb begin
        w_pc_nxt = w_seq_pc;
        if (set_pc) begin
            w_pc_nxt = pc_target;
        end else if (add_pc) begin
            w_pc_nxt = r_cur_pc + pc_target;
        end else if (inc_pc) begin
            w_pc_nxt = w_seq_pc;
        end
    end

    // State register
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH_I;
            end
            S_FETCH_I: begin
                if (mem_ack) w_state_nxt = w_need_ext ? S_FETCH_E : S_ISSUE;
            end
            S_FETCH_E: begin
                if (mem_ack) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) w_state_nxt = run ? S_FETCH_I : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: PC, issued instruction and its extension word
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_pc      <= RESET_PC;
            r_cur_pc  <= RESET_PC;
            r_ins     <= 16'h0000;
            r_ext     <= 16'h0000;
            r_has_ext <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH_I: begin
                    if (mem_ack) begin
                        r_ins     <= mem_rdata;
                        r_cur_pc  <= r_pc;
                        r_has_ext <= w_need_ext;
                        if (!w_need_ext) r_ext <= 16'h0000;
                    end
                end
                S_FETCH_E: begin
                    if (mem_ack) r_ext <= mem_rdata;
                end
                S_EXEC: begin
                    if (exec_done) r_pc <= w_pc_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from registered state only; mem_addr is held by the
    // state and r_pc, neither of which moves until the ack is taken.
    assign mem_req  = (r_state == S_FETCH_I) || (r_state == S_FETCH_E);
    assign mem_addr = (r_state == S_FETCH_I) ? r_pc :
                      (r_state == S_FETCH_E) ? (r_pc + 16'd1) : 16'h0000;
    assign ins_en   = (r_state == S_ISSUE);
    assign idle     = (r_state == S_IDLE);
    assign ins      = r_ins;
    assign ext      = r_ext;
    assign cur_pc   = r_cur_pc;

endmodule
`default_nettype wire
